// File: rtl/ap3_fifo_reader.sv
// ap3_fifo_reader
//
// Read-side controller for an AP3 RAM block in FIFO mode. Drives the RAM's
// REN and FFLUSH, watches its flags, absorbs the one-cycle RDATA latency and
// hands the popped words to fabric logic as a valid/ready stream through a
// 2-entry buffer, so back-pressure never drops a word.
//
// Parameters
//   DATA_WIDTH   : stream / RDATA width (8, 16 or 32, matching the RAM RMODE)
//   FLUSH_CYCLES : cycles FFLUSH is held per flush (1..15)
//
// Ports
//   RCLK       in   read clock, shared with the RAM
//   RST_N      in   asynchronous active-low reset
//   FFLAGS     in   [0] EMPTY, [1] ALMOST_EMPTY, [3:2] not used
//   RDATA      in   RAM read data, valid the cycle after REN
//   REN        out  RAM read enable (combinational)
//   FFLUSH     out  RAM FIFO flush
//   FLUSH_REQ  in   single-cycle flush request
//   M_DATA     out  stream data (buffer head)
//   M_VALID    out  stream valid
//   M_READY    in   stream ready
//   BUSY       out  high while flushing
//   RD_COUNT   out  16-bit pop counter, present only when the macro
//                   AP3_FIFO_RD_COUNT_EN is defined

module ap3_fifo_reader #(
    parameter int DATA_WIDTH   = 32,
    parameter int FLUSH_CYCLES = 4
) (
    input  logic                  RCLK,
    input  logic                  RST_N,
    input  logic [3:0]            FFLAGS,
    input  logic [DATA_WIDTH-1:0] RDATA,
    output logic                  REN,
    output logic                  FFLUSH,
    input  logic                  FLUSH_REQ,
    output logic [DATA_WIDTH-1:0] M_DATA,
    output logic                  M_VALID,
    input  logic                  M_READY,
    output logic                  BUSY
`ifdef AP3_FIFO_RD_COUNT_EN
    ,
    output logic [15:0]           RD_COUNT
`endif
);

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    localparam logic [3:0] FLUSH_LAST = 4'(FLUSH_CYCLES - 1);

    state_t                 state_q;
    state_t                 state_d;
    logic [3:0]             flush_cnt_q;
    logic                   vld_p1;       // RDATA carries a word this cycle
    logic [1:0]             occ_q;
    logic [DATA_WIDTH-1:0]  head_q;
    logic [DATA_WIDTH-1:0]  tail_q;

    logic                   fifo_empty;
    logic                   almost_empty;
    logic                   pop;
    logic                   push;
    logic [2:0]             credit_used;
    logic [2:0]             credit_limit;
    logic                   credit_ok;
    logic                   guard;
    logic                   ren_d;
    logic                   flush_enter;
    logic                   unused_flags;

    assign fifo_empty   = FFLAGS[0];
    assign almost_empty = FFLAGS[1];
    assign unused_flags = ^FFLAGS[3:2];

    assign M_VALID = (occ_q != 2'd0);
    assign M_DATA  = head_q;
    assign pop     = M_VALID & M_READY;
    assign push    = vld_p1;

    // occ + inflight - pop < 2, rearranged to avoid an unsigned underflow
    assign credit_used  = {1'b0, occ_q} + {2'b00, vld_p1};
    assign credit_limit = 3'd2 + {2'b00, pop};
    assign credit_ok    = (credit_used < credit_limit);

    // The RAM's ALMOST_EMPTY lags a read by a cycle; never issue a second
    // read back-to-back when the FIFO may be down to its last word.
    assign guard = vld_p1 & almost_empty;

    always_comb begin
        state_d     = state_q;
        ren_d       = 1'b0;
        flush_enter = 1'b0;
        case (state_q)
            RUN: begin
                if (FLUSH_REQ) begin
                    state_d     = FLUSH;
                    flush_enter = 1'b1;
                end else begin
                    ren_d = credit_ok & ~fifo_empty & ~guard;
                end
            end
            FLUSH: begin
                if (flush_cnt_q == FLUSH_LAST) begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    // Gating with RST_N keeps REN low during reset without waiting for a clock.
    assign REN    = ren_d & RST_N;
    assign FFLUSH = (state_q == FLUSH);
    assign BUSY   = (state_q == FLUSH);

    // ---- stage p0 -> p1: state, in-flight read, output buffer ----
    always_ff @(posedge RCLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= RUN;
            flush_cnt_q <= 4'd0;
            vld_p1      <= 1'b0;
            occ_q       <= 2'd0;
            head_q      <= '0;
            tail_q      <= '0;
        end else begin
            state_q <= state_d;
            vld_p1  <= REN;
            if (flush_enter) begin
                // Emptying the buffer also drops the word returning this cycle.
                occ_q       <= 2'd0;
                flush_cnt_q <= 4'd0;
            end else begin
                if (state_q == FLUSH) begin
                    flush_cnt_q <= flush_cnt_q + 4'd1;
                end
                case (occ_q)
                    2'd0: begin
                        if (push) begin
                            head_q <= RDATA;
                            occ_q  <= 2'd1;
                        end
                    end
                    2'd1: begin
                        case ({push, pop})
                            2'b11:   head_q <= RDATA;
                            2'b10: begin
                                tail_q <= RDATA;
                                occ_q  <= 2'd2;
                            end
                            2'b01:   occ_q  <= 2'd0;
                            default: ;
                        endcase
                    end
                    default: begin
                        // Full: the credit rule guarantees no push without a pop.
                        if (pop) begin
                            head_q <= tail_q;
                            if (push) begin
                                tail_q <= RDATA;
                            end else begin
                                occ_q <= 2'd1;
                            end
                        end
                    end
                endcase
            end
        end
    end

`ifdef AP3_FIFO_RD_COUNT_EN
    logic [15:0] rd_count_q;

    always_ff @(posedge RCLK or negedge RST_N) begin
        if (!RST_N) begin
            rd_count_q <= 16'd0;
        end else if (flush_enter) begin
            rd_count_q <= 16'd0;
        end else if (pop) begin
            rd_count_q <= rd_count_q + 16'd1;
        end
    end

    assign RD_COUNT = rd_count_q;
`endif

endmodule

// File: doc/ap3_fifo_reader.md
# ap3_fifo_reader

Read-side controller for an AP3 RAM block configured in FIFO mode (FMODE=1). It drives the RAM's REN and FFLUSH, watches FFLAGS, absorbs the RAM's fixed one-cycle read latency, and presents the popped words to fabric logic as a valid/ready stream. The stream output uses a 2-entry buffer, so back-pressure never loses data. It sits between the RAM primitive's read port and the consuming fabric logic, in the same RCLK domain.

## Interface
Parameters:
- DATA_WIDTH, 32: stream and RDATA width used; must be 8, 16 or 32, matching the RAM's RMODE.
- FLUSH_CYCLES, 4: number of cycles FFLUSH is held high per flush; range 1..15.

Ports:
- Clocking and reset (already decided): one clock; reset is asynchronous and active-low.
- RCLK  in  1  read clock, shared with the RAM's RCLK.
- RST_N  in  1  asynchronous active-low reset.
- FFLAGS  in  4  RAM FIFO flags: [0] EMPTY, [1] ALMOST_EMPTY (UPAE level), [2] ALMOST_FULL, [3] FULL; bits [3:2] unused.
- RDATA  in  DATA_WIDTH  RAM read data, valid one cycle after REN is sampled.
- REN  out  1  RAM read enable.
- FFLUSH  out  1  RAM FIFO flush.
- FLUSH_REQ  in  1  single-cycle request to flush the FIFO.
- M_DATA  out  DATA_WIDTH  stream data.
- M_VALID  out  1  stream valid.
- M_READY  in  1  stream ready.
- BUSY  out  1  high while in the FLUSH state.

## Operation
- States: RUN, FLUSH.
- Reset state: RUN. Reset values: REN=0, FFLUSH=0, M_VALID=0, M_DATA=0, BUSY=0. Buffer and in-flight flag are cleared.

RUN state:
- Credit rule: occ + inflight − pop < 2, where:
  - occ = buffer occupancy (0..2);
  - inflight = REN was asserted in the previous cycle;
  - pop = M_VALID & M_READY.
- REN is combinational. It is asserted when the credit rule holds, EMPTY=0, and no flush is requested this cycle.
- Underflow guard: if REN was high last cycle and ALMOST_EMPTY=1, REN stays low this cycle. This covers the RAM flag update lag.
- Returned RDATA is written into the buffer tail in the cycle it is valid. M_DATA is always the buffer head.
- A simultaneous push and pop keeps the order intact.

FLUSH state:
- FLUSH_REQ=1 in RUN moves to FLUSH on the next edge.
- On entry: buffer cleared, M_VALID=0, any in-flight read discarded (its RDATA is ignored).
- FFLUSH=1 and BUSY=1 for exactly FLUSH_CYCLES cycles, then back to RUN.
- REN=0 throughout FLUSH.
- FLUSH_REQ is ignored while in FLUSH.

## Timing
- Read latency: REN high in cycle n, RDATA valid in cycle n+1, M_VALID=1 in cycle n+2.
- Throughput: 1 word/cycle while ALMOST_EMPTY=0 and M_READY=1. With ALMOST_EMPTY=1 it is at most 1 word per 2 cycles.
- M_VALID/M_DATA are registered and hold stable while M_VALID=1 and M_READY=0.
- FLUSH_REQ in cycle n:
  - REN=0 in cycle n;
  - FFLUSH=1 in cycles n+1 .. n+FLUSH_CYCLES;
  - REN may assert again from cycle n+FLUSH_CYCLES+1.
- RST_N low mid-operation: all outputs go to reset values immediately, with no clock needed. Deassertion is synchronised externally.

## Configuration
- Macro: AP3_FIFO_RD_COUNT_EN.
- Defined: adds output RD_COUNT (out, 16 bits).
  - Increments on every pop and wraps from 0xFFFF to 0.
  - Cleared by reset and on entry to FLUSH.
- Undefined: the port and counter are absent; all other behaviour is identical.

## Test plan
- Back-to-back drain: FIFO preloaded with 0x11,0x22,0x33, ALMOST_EMPTY=0, M_READY=1 → REN high cycles 0–2; M_DATA 0x11,0x22,0x33 with M_VALID high in cycles 2–4.
- Back-pressure: M_READY=0 with 3 words available → REN stops after 2 words; M_DATA holds 0x11. Raising M_READY → order 0x11,0x22,0x33 with no loss.
- Almost-empty guard: ALMOST_EMPTY=1, EMPTY=0, M_READY=1 → REN never high in two consecutive cycles; no REN while EMPTY=1.
- Flush with a read in flight: FLUSH_REQ the cycle after REN, FLUSH_CYCLES=4 → FFLUSH high exactly 4 cycles; in-flight RDATA is never presented; M_VALID=0 until new data arrives.
- Reset mid-stream: RST_N low with 2 words buffered → M_VALID=0, REN=0, FFLUSH=0 asynchronously. After release, the first word read appears 2 cycles after REN.
- With AP3_FIFO_RD_COUNT_EN defined: 70000 pops → RD_COUNT=4464 (after wrapping); a flush → RD_COUNT=0.
